// File: rtl/opcode_flag_decoder.sv
// opcode_flag_decoder
// Captures the fetched instruction into the instruction register during FETCH
// ({s2,s1,s0} == 3'b000). It also registers a one-hot instruction-class decode
// that the state manager consumes. The flags stay stable for the whole
// instruction. A sticky flag records illegal opcodes, and a counter tracks
// loaded instructions.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        synchronous active-high reset
//   s2, s1, s0   current state bits from the state manager
//   instr_in     instruction word from instruction memory
//   instr_valid  instr_in valid this cycle
//   ir           instruction register
//   alu, ld, st, push, pop, jump, be  registered one-hot class flags
//   illegal      sticky illegal-opcode indicator
//   fetch_count  number of instructions loaded (wraps silently)
module opcode_flag_decoder #(
  parameter int unsigned INSTR_W = 18,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned OP_LSB  = 14,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s2,
  input  logic               s1,
  input  logic               s0,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  output logic [INSTR_W-1:0] ir,
  output logic               alu,
  output logic               ld,
  output logic               st,
  output logic               push,
  output logic               pop,
  output logic               jump,
  output logic               be,
  output logic               illegal,
  output logic [CNT_W-1:0]   fetch_count
);

  // Flag vector order: {alu, ld, st, push, pop, jump, be}
  logic [6:0]      flags_q;
  logic [6:0]      dec_flags;
  logic            dec_illegal;
  logic [OP_W-1:0] opcode;
  logic            fetch;

  assign fetch  = ({s2, s1, s0} == 3'b000);
  assign opcode = instr_in[OP_LSB +: OP_W];

  always_comb begin
    dec_flags   = 7'b0;
    dec_illegal = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h2,
      4'h3, 4'h4, 4'h5: dec_flags = 7'b1000000;
      4'h6:             dec_flags = 7'b0100000;
      4'h7:             dec_flags = 7'b0010000;
      4'h8:             dec_flags = 7'b0001000;
      4'h9:             dec_flags = 7'b0000100;
      4'hA:             dec_flags = 7'b0000010;
      4'hB:             dec_flags = 7'b0000001;
      default:          dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir          <= '0;
      flags_q     <= '0;
      illegal     <= 1'b0;
      fetch_count <= '0;
    end else if (fetch) begin
      if (instr_valid) begin
        ir          <= instr_in;
        flags_q     <= dec_flags;
        fetch_count <= fetch_count + 1'b1;
        if (dec_illegal) begin
          illegal <= 1'b1;
        end
      end else begin
        // A bubble clears every flag, so the state manager loops back to FETCH.
        flags_q <= '0;
      end
    end
    // Non-FETCH states hold everything, so flags stay stable mid-instruction.
  end

  assign {alu, ld, st, push, pop, jump, be} = flags_q;

endmodule
